la_tx_buffer: RTL and testbench

- Downstream of the logic-analyzer sampler. Buffers its 32-bit sample packets in a circular FIFO and presents them to the host TX path over a valid/ready handshake.
- On overflow, drops incoming samples and counts them. When space frees, inserts a single overflow-marker packet in stream order, so the host can detect and size each gap.

---
 rtl/la_pkg.sv | 25 ++
 rtl/la_sync_fifo.sv | 59 +++++
 rtl/la_tx_buffer.sv | 101 ++++++++++
 tb/tb_la_tx_buffer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared constants, state type and marker-packet builder for the logic-analyzer TX path.
package la_pkg;

  localparam logic [1:0] LA_PERIPH_ID  = 2'b10;
  localparam int         PERIPH_ID_MSB = 27;
  localparam int         PERIPH_ID_LSB = 26;
  localparam int         OVF_FLAG_BIT  = 25;
  localparam int         DATA_MSB      = 15;
  localparam int         DATA_LSB      = 0;

  typedef enum logic {
    NORMAL   = 1'b0,
    DROPPING = 1'b1
  } la_state_t;

  function automatic logic [31:0] make_ovf_marker(input logic [15:0] count);
    logic [31:0] pkt;
    pkt = '0;
    pkt[PERIPH_ID_MSB:PERIPH_ID_LSB] = LA_PERIPH_ID;
    pkt[OVF_FLAG_BIT]                = 1'b1;
    pkt[DATA_MSB:DATA_LSB]           = count;
    return pkt;
  endfunction

endpackage

// File: rtl/la_sync_fifo.sv
// Show-ahead synchronous FIFO: rd_data is the head entry, popped by rd_en.
// Pushes into a full FIFO are taken only when a pop happens in the same cycle.
module la_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign pop   = rd_en && !empty;
  assign push  = wr_en && (!full || pop);

  // Head is forced to zero while empty so the output is defined without resetting storage.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage carries no reset; pointers and count define validity, and a
  // reset-free array maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/la_tx_buffer.sv
// Sample buffer toward host TX: drops samples on overflow, counts them, and
// inserts one in-order overflow marker as soon as space frees.
module la_tx_buffer
  import la_pkg::*;
#(
  parameter int width = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [width-1:0]       packet_in,
  input  logic                   data_valid,
  output logic [width-1:0]       tx_packet,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow_sticky,
  input  logic                   clr_sticky
);

  la_state_t        state, state_next;
  logic [CNT_W-1:0] drop_cnt, drop_cnt_next, drop_cnt_inc;
  logic             pop;
  logic             can_write;
  logic             wr_en;
  logic [width-1:0] wr_data;
  logic             drop_event;

  assign tx_valid     = !empty;
  assign pop          = tx_valid && tx_ready;
  assign can_write    = !full || pop;
  assign drop_cnt_inc = (drop_cnt == '1) ? drop_cnt : drop_cnt + CNT_W'(1);

  la_sync_fifo #(
    .WIDTH (width),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (tx_ready),
    .rd_data (tx_packet),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_next    = state;
    drop_cnt_next = drop_cnt;
    wr_en         = 1'b0;
    wr_data       = packet_in;
    drop_event    = 1'b0;
    case (state)
      NORMAL: begin
        if (data_valid) begin
          if (can_write) begin
            wr_en = 1'b1;
          end else begin
            drop_event    = 1'b1;
            drop_cnt_next = CNT_W'(1);
            state_next    = DROPPING;
          end
        end
      end
      DROPPING: begin
        if (can_write) begin
          // A sample arriving in the recovery cycle is still lost; fold it into this marker.
          wr_en         = 1'b1;
          wr_data       = make_ovf_marker(16'(data_valid ? drop_cnt_inc : drop_cnt));
          drop_event    = data_valid;
          drop_cnt_next = '0;
          state_next    = NORMAL;
        end else if (data_valid) begin
          drop_event    = 1'b1;
          drop_cnt_next = drop_cnt_inc;
        end
      end
      default: state_next = NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= NORMAL;
      drop_cnt        <= '0;
      overflow_sticky <= 1'b0;
    end else begin
      state    <= state_next;
      drop_cnt <= drop_cnt_next;
      if (drop_event)      overflow_sticky <= 1'b1;
      else if (clr_sticky) overflow_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_la_tx_buffer.sv
// Directed bench for la_tx_buffer: pass-through, backpressure, overflow markers,
// saturation, full push/pop and mid-stream reset.
module tb_la_tx_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] packet_in = '0;
  logic        data_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic        clr_sticky = 1'b0;
  logic [31:0] tx_packet;
  logic        tx_valid;
  logic [4:0]  fifo_count;
  logic        full;
  logic        empty;
  logic        overflow_sticky;

  int checks = 0;
  int errors = 0;

  la_tx_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .packet_in       (packet_in),
    .data_valid      (data_valid),
    .tx_packet       (tx_packet),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .fifo_count      (fifo_count),
    .full            (full),
    .empty           (empty),
    .overflow_sticky (overflow_sticky),
    .clr_sticky      (clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] d);
    data_valid = 1'b1;
    packet_in  = d;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %0b want 0", tx_valid); end
    checks++; if (tx_packet !== 32'h0) begin errors++; $display("FAIL reset_tx_packet: got %08h want 00000000", tx_packet); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: empty=%0b full=%0b want 1/0", empty, full); end
    checks++; if (overflow_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %0b want 0", overflow_sticky); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pass_through();
    tx_ready   = 1'b1;
    data_valid = 1'b1;
    packet_in  = 32'h0800_1234;
    tick();
    checks++; if (tx_valid !== 1'b1 || tx_packet !== 32'h0800_1234) begin errors++; $display("FAIL pass_first: valid=%0b pkt=%08h want 1/08001234", tx_valid, tx_packet); end
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL pass_count1: got %0d want 1", fifo_count); end
    packet_in = 32'h0800_ABCD;
    tick();
    data_valid = 1'b0;
    checks++; if (tx_valid !== 1'b1 || tx_packet !== 32'h0800_ABCD) begin errors++; $display("FAIL pass_second: valid=%0b pkt=%08h want 1/0800abcd", tx_valid, tx_packet); end
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL pass_count2: got %0d want 1", fifo_count); end
    tick();
    checks++; if (empty !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL pass_drained: empty=%0b valid=%0b want 1/0", empty, tx_valid); end
    checks++; if (overflow_sticky !== 1'b0) begin errors++; $display("FAIL pass_sticky: got %0b want 0", overflow_sticky); end
    tx_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [3];
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp[i] = 32'h0800_0001 + 32'(i);
      push_one(exp[i]);
    end
    checks++; if (fifo_count !== 5'd3) begin errors++; $display("FAIL bp_count: got %0d want 3", fifo_count); end
    tick();
    checks++; if (tx_packet !== 32'h0800_0001) begin errors++; $display("FAIL bp_hold: got %08h want 08000001", tx_packet); end
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_packet !== exp[i]) begin errors++; $display("FAIL bp_drain%0d: valid=%0b pkt=%08h want 1/%08h", i, tx_valid, tx_packet, exp[i]); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bp_empty: got %0b want 1", empty); end
    tx_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] exp [18];
    tx_ready = 1'b0;
    for (int i = 0; i < 21; i++) push_one(32'h0800_0100 + 32'(i));
    checks++; if (full !== 1'b1 || fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_full: full=%0b count=%0d want 1/16", full, fifo_count); end
    checks++; if (overflow_sticky !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", overflow_sticky); end
    for (int i = 0; i < 16; i++) exp[i] = 32'h0800_0100 + 32'(i);
    exp[16] = 32'h0A00_0005;
    exp[17] = 32'h0800_0300;
    tx_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_packet !== exp[i]) begin errors++; $display("FAIL ovf_read%0d: valid=%0b pkt=%08h want 1/%08h", i, tx_valid, tx_packet, exp[i]); end
      data_valid = (i == 5);
      packet_in  = 32'h0800_0300;
      tick();
      data_valid = 1'b0;
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_single_marker: empty=%0b pkt=%08h want empty", empty, tx_packet); end
    tx_ready   = 1'b0;
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checks++; if (overflow_sticky !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b want 0", overflow_sticky); end
  endtask

  task automatic test_full_push_pop();
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_one(32'h0800_0400 + 32'(i));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fpp_full: got %0b want 1", full); end
    tx_ready   = 1'b1;
    data_valid = 1'b1;
    packet_in  = 32'h0800_0500;
    tick();
    data_valid = 1'b0;
    tx_ready   = 1'b0;
    checks++; if (fifo_count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL fpp_count: count=%0d full=%0b want 16/1", fifo_count, full); end
    checks++; if (overflow_sticky !== 1'b0) begin errors++; $display("FAIL fpp_sticky: got %0b want 0", overflow_sticky); end
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] e;
      e = (i < 15) ? 32'h0800_0401 + 32'(i) : 32'h0800_0500;
      checks++; if (tx_valid !== 1'b1 || tx_packet !== e) begin errors++; $display("FAIL fpp_read%0d: valid=%0b pkt=%08h want 1/%08h", i, tx_valid, tx_packet, e); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fpp_no_marker: empty=%0b pkt=%08h want empty", empty, tx_packet); end
    tx_ready = 1'b0;
  endtask

  task automatic test_saturation();
    int          drops [2];
    logic [31:0] marker [2];
    drops[0] = 70000; marker[0] = 32'h0A00_FFFF;
    drops[1] = 3;     marker[1] = 32'h0A00_0004;
    for (int c = 0; c < 2; c++) begin
      tx_ready = 1'b0;
      for (int i = 0; i < 16; i++) push_one(32'h0800_0600 + 32'(i));
      data_valid = 1'b1;
      packet_in  = 32'h0800_0777;
      for (int k = 0; k < drops[c]; k++) tick();
      checks++; if (overflow_sticky !== 1'b1 || full !== 1'b1) begin errors++; $display("FAIL sat%0d_state: sticky=%0b full=%0b want 1/1", c, overflow_sticky, full); end
      tx_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
        logic [31:0] e;
        e = (i < 16) ? 32'h0800_0600 + 32'(i) : marker[c];
        checks++; if (tx_valid !== 1'b1 || tx_packet !== e) begin errors++; $display("FAIL sat%0d_read%0d: valid=%0b pkt=%08h want 1/%08h", c, i, tx_valid, tx_packet, e); end
        tick();
        data_valid = 1'b0;
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sat%0d_empty: got %0b want 1", c, empty); end
      tx_ready   = 1'b0;
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    for (int i = 0; i < 18; i++) push_one(32'h0800_0800 + 32'(i));
    checks++; if (overflow_sticky !== 1'b1 || fifo_count !== 5'd16) begin errors++; $display("FAIL rmid_pre: sticky=%0b count=%0d want 1/16", overflow_sticky, fifo_count); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL rmid_async: valid=%0b empty=%0b want 0/1", tx_valid, empty); end
    checks++; if (fifo_count !== 5'd0 || overflow_sticky !== 1'b0) begin errors++; $display("FAIL rmid_state: count=%0d sticky=%0b want 0/0", fifo_count, overflow_sticky); end
    tick();
    rst      = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale%0d: valid=%0b pkt=%08h want 0", i, tx_valid, tx_packet); end
    end
    push_one(32'h0800_0900);
    checks++; if (tx_valid !== 1'b1 || tx_packet !== 32'h0800_0900) begin errors++; $display("FAIL rmid_resume: valid=%0b pkt=%08h want 1/08000900", tx_valid, tx_packet); end
    tick();
    checks++; if (empty !== 1'b1 || overflow_sticky !== 1'b0) begin errors++; $display("FAIL rmid_end: empty=%0b sticky=%0b want 1/0", empty, overflow_sticky); end
    tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
